// File: rtl/umi_gpio_ctrl.sv
//------------------------------------------------------------------------------
// umi_gpio_ctrl
//
// Host-side UMI controller for a UMI GPIO device. Local logic writes the GPIO
// outputs through a set_valid/set_ready handshake and requests input samples
// with sample_req. Each operation becomes one non-posted UMI request (write or
// read), and only one request is outstanding at a time. A free-running poll
// timer also schedules a read every POLL_CYCLES cycles so that gpio_in_q stays
// fresh without local intervention.
//
// Ports:
//   clk, nreset           clock, synchronous active-low reset
//   set_valid/set_ready   local write handshake, set_data is the output value
//   sample_req            one-cycle pulse requesting an immediate read
//   gpio_in_q             last sampled GPIO input value
//   gpio_in_upd           one-cycle pulse when gpio_in_q takes a new value
//   busy                  high while a transaction is in progress
//   error                 sticky flag, set on an unexpected response opcode
//   uhost_req_*           UMI request channel towards the device
//   uhost_resp_*          UMI response channel from the device
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no transaction; accepts set requests or issues pending read
// WR_REQ  | write request presented, waiting for uhost_req_ready
// WR_RESP | waiting for the write response
// RD_REQ  | read request presented, waiting for uhost_req_ready
// RD_RESP | waiting for the read response carrying the input value
//------------------------------------------------------------------------------
module umi_gpio_ctrl #(
  parameter int          DW          = 256,
  parameter int          AW          = 64,
  parameter int          CW          = 32,
  parameter int          RWIDTH      = 32,
  parameter int          WWIDTH      = 32,
  parameter logic [AW-1:0] GPIO_ADDR = '0,
  parameter logic [AW-1:0] SRC_ADDR  = '0,
  parameter int          POLL_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              set_valid,
  input  logic [WWIDTH-1:0] set_data,
  output logic              set_ready,
  input  logic              sample_req,
  output logic [RWIDTH-1:0] gpio_in_q,
  output logic              gpio_in_upd,
  output logic              busy,
  output logic              error,
  output logic              uhost_req_valid,
  output logic [CW-1:0]     uhost_req_cmd,
  output logic [AW-1:0]     uhost_req_dstaddr,
  output logic [AW-1:0]     uhost_req_srcaddr,
  output logic [DW-1:0]     uhost_req_data,
  input  logic              uhost_req_ready,
  input  logic              uhost_resp_valid,
  input  logic [CW-1:0]     uhost_resp_cmd,
  input  logic [AW-1:0]     uhost_resp_dstaddr,
  input  logic [AW-1:0]     uhost_resp_srcaddr,
  input  logic [DW-1:0]     uhost_resp_data,
  output logic              uhost_resp_ready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP
  } state_t;

  localparam logic [4:0] REQ_READ   = 5'h01;
  localparam logic [4:0] REQ_WRITE  = 5'h03;
  localparam logic [4:0] RESP_READ  = 5'h02;
  localparam logic [4:0] RESP_WRITE = 5'h04;

  // size field is log2 of the byte count of the transferred width
  localparam logic [2:0] WSIZE = 3'($clog2((WWIDTH + 7) / 8));
  localparam logic [2:0] RSIZE = 3'($clog2((RWIDTH + 7) / 8));

  function automatic logic [CW-1:0] umi_cmd(input logic [4:0] opcode,
                                            input logic [2:0] size);
    logic [CW-1:0] c;
    c      = '0;
    c[4:0] = opcode;
    c[7:5] = size;
    return c;
  endfunction

  localparam logic [CW-1:0] WR_CMD = umi_cmd(REQ_WRITE, WSIZE);
  localparam logic [CW-1:0] RD_CMD = umi_cmd(REQ_READ, RSIZE);

  state_t state;
  logic   rd_pending;
  logic   poll_wrap;

  // Response addresses and the unused upper response bits carry nothing
  // this controller needs.
  logic unused_resp;
  assign unused_resp = ^{uhost_resp_dstaddr, uhost_resp_srcaddr,
                         uhost_resp_data, uhost_resp_cmd};

  //----------------------------------------------------------------------------
  // Poll timer: counts 0..POLL_CYCLES-1 in every state, wrap requests a read.
  //----------------------------------------------------------------------------
  generate
    if (POLL_CYCLES == 0) begin : g_no_poll
      assign poll_wrap = 1'b0;
    end else begin : g_poll
      localparam int PW = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
      localparam logic [PW-1:0] LAST = PW'(POLL_CYCLES - 1);
      logic [PW-1:0] poll_cnt;

      always_ff @(posedge clk) begin
        if (!nreset) begin
          poll_cnt <= '0;
        end else if (poll_cnt == LAST) begin
          poll_cnt <= '0;
        end else begin
          poll_cnt <= poll_cnt + PW'(1);
        end
      end

      assign poll_wrap = (poll_cnt == LAST);
    end
  endgenerate

  assign busy = (state != IDLE);

  //----------------------------------------------------------------------------
  // Transaction FSM with registered outputs
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!nreset) begin
      state             <= IDLE;
      rd_pending        <= 1'b0;
      set_ready         <= 1'b0;
      gpio_in_q         <= '0;
      gpio_in_upd       <= 1'b0;
      error             <= 1'b0;
      uhost_req_valid   <= 1'b0;
      uhost_req_cmd     <= '0;
      uhost_req_dstaddr <= '0;
      uhost_req_srcaddr <= '0;
      uhost_req_data    <= '0;
      uhost_resp_ready  <= 1'b0;
    end else begin
      gpio_in_upd <= 1'b0;
      if (sample_req || poll_wrap) begin
        rd_pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (set_valid && set_ready) begin
            state             <= WR_REQ;
            set_ready         <= 1'b0;
            uhost_req_valid   <= 1'b1;
            uhost_req_cmd     <= WR_CMD;
            uhost_req_dstaddr <= GPIO_ADDR;
            uhost_req_srcaddr <= SRC_ADDR;
            uhost_req_data    <= DW'(set_data);
          end else if (rd_pending) begin
            // A trigger arriving in the issue cycle is served by this read.
            state             <= RD_REQ;
            rd_pending        <= 1'b0;
            set_ready         <= 1'b0;
            uhost_req_valid   <= 1'b1;
            uhost_req_cmd     <= RD_CMD;
            uhost_req_dstaddr <= GPIO_ADDR;
            uhost_req_srcaddr <= SRC_ADDR;
            uhost_req_data    <= '0;
          end else begin
            set_ready <= 1'b1;
          end
        end

        WR_REQ: begin
          if (uhost_req_ready) begin
            state            <= WR_RESP;
            uhost_req_valid  <= 1'b0;
            uhost_resp_ready <= 1'b1;
          end
        end

        RD_REQ: begin
          if (uhost_req_ready) begin
            state            <= RD_RESP;
            uhost_req_valid  <= 1'b0;
            uhost_resp_ready <= 1'b1;
          end
        end

        WR_RESP: begin
          if (uhost_resp_valid) begin
            state            <= IDLE;
            uhost_resp_ready <= 1'b0;
            set_ready        <= 1'b1;
            if (uhost_resp_cmd[4:0] != RESP_WRITE) begin
              error <= 1'b1;
            end
          end
        end

        RD_RESP: begin
          if (uhost_resp_valid) begin
            state            <= IDLE;
            uhost_resp_ready <= 1'b0;
            set_ready        <= 1'b1;
            if (uhost_resp_cmd[4:0] == RESP_READ) begin
              gpio_in_q   <= uhost_resp_data[RWIDTH-1:0];
              gpio_in_upd <= 1'b1;
            end else begin
              error <= 1'b1;
            end
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_umi_gpio_ctrl.sv
module tb_umi_gpio_ctrl;

  localparam logic [63:0] GA     = 64'h0000_0000_4000_1000;
  localparam logic [63:0] SA     = 64'h0000_0000_0000_2000;
  localparam logic [31:0] CMD_WR = 32'h0000_0043;  // opcode 3, size 2, len 0
  localparam logic [31:0] CMD_RD = 32'h0000_0041;  // opcode 1, size 2, len 0
  localparam logic [31:0] RSP_RD = 32'h0000_0002;
  localparam logic [31:0] RSP_WR = 32'h0000_0004;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         nreset;
  // main DUT, polling disabled
  logic         set_valid, set_ready, sample_req, gpio_in_upd, busy, error;
  logic [31:0]  set_data, gpio_in_q;
  logic         uhost_req_valid, uhost_req_ready, uhost_resp_valid, uhost_resp_ready;
  logic [31:0]  uhost_req_cmd, uhost_resp_cmd;
  logic [63:0]  uhost_req_dstaddr, uhost_req_srcaddr, uhost_resp_dstaddr, uhost_resp_srcaddr;
  logic [255:0] uhost_req_data, uhost_resp_data;
  // poll DUT, POLL_CYCLES=16 with an always-ready device
  logic         p_set_ready, p_gpio_in_upd, p_busy, p_error;
  logic [31:0]  p_gpio_in_q, p_req_cmd;
  logic         p_req_valid, p_resp_ready;
  logic [63:0]  p_req_dstaddr, p_req_srcaddr;
  logic [255:0] p_req_data;

  umi_gpio_ctrl #(.GPIO_ADDR(GA), .SRC_ADDR(SA), .POLL_CYCLES(0)) dut (
    .clk(clk), .nreset(nreset),
    .set_valid(set_valid), .set_data(set_data), .set_ready(set_ready),
    .sample_req(sample_req), .gpio_in_q(gpio_in_q), .gpio_in_upd(gpio_in_upd),
    .busy(busy), .error(error),
    .uhost_req_valid(uhost_req_valid), .uhost_req_cmd(uhost_req_cmd),
    .uhost_req_dstaddr(uhost_req_dstaddr), .uhost_req_srcaddr(uhost_req_srcaddr),
    .uhost_req_data(uhost_req_data), .uhost_req_ready(uhost_req_ready),
    .uhost_resp_valid(uhost_resp_valid), .uhost_resp_cmd(uhost_resp_cmd),
    .uhost_resp_dstaddr(uhost_resp_dstaddr), .uhost_resp_srcaddr(uhost_resp_srcaddr),
    .uhost_resp_data(uhost_resp_data), .uhost_resp_ready(uhost_resp_ready)
  );

  umi_gpio_ctrl #(.GPIO_ADDR(GA), .SRC_ADDR(SA), .POLL_CYCLES(16)) dut_poll (
    .clk(clk), .nreset(nreset),
    .set_valid(1'b0), .set_data(32'h0), .set_ready(p_set_ready),
    .sample_req(1'b0), .gpio_in_q(p_gpio_in_q), .gpio_in_upd(p_gpio_in_upd),
    .busy(p_busy), .error(p_error),
    .uhost_req_valid(p_req_valid), .uhost_req_cmd(p_req_cmd),
    .uhost_req_dstaddr(p_req_dstaddr), .uhost_req_srcaddr(p_req_srcaddr),
    .uhost_req_data(p_req_data), .uhost_req_ready(1'b1),
    .uhost_resp_valid(1'b1), .uhost_resp_cmd(RSP_RD),
    .uhost_resp_dstaddr(64'h0), .uhost_resp_srcaddr(64'h0),
    .uhost_resp_data(256'h5A), .uhost_resp_ready(p_resp_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string nm, input logic [255:0] act,
                                input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  // handshake counters and poll-read timestamps
  int hs_cnt = 0;
  int cyc    = 0;
  int p_times[$];

  always @(posedge clk) begin
    if (uhost_req_valid && uhost_req_ready) hs_cnt <= hs_cnt + 1;
    if (nreset) begin
      if (p_req_valid && cyc < 100) p_times.push_back(cyc);
      cyc <= cyc + 1;
    end
  end

  task automatic start_set(input logic [31:0] d, input logic with_sample);
    int n = 0;
    while (!set_ready && n < 20) begin @(negedge clk); n++; end
    check("set_ready_before_set", set_ready, 1);
    set_valid  = 1'b1;
    set_data   = d;
    sample_req = with_sample;
    @(negedge clk);
    set_valid  = 1'b0;
    sample_req = 1'b0;
  endtask

  task automatic pulse_sample;
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
  endtask

  // Acts as the device for one transaction.
  task automatic serve(input logic is_wr, input logic [31:0] exp_data,
                       input int wait_n, input logic [31:0] rcmd,
                       input logic [31:0] rdata);
    int n = 0;
    logic [31:0] exp_cmd;
    exp_cmd = is_wr ? CMD_WR : CMD_RD;
    while (!uhost_req_valid && n < 20) begin @(negedge clk); n++; end
    check("req_valid", uhost_req_valid, 1);
    check("req_cmd", uhost_req_cmd, exp_cmd);
    check("req_dstaddr", uhost_req_dstaddr, GA);
    check("req_srcaddr", uhost_req_srcaddr, SA);
    check("busy_in_req", busy, 1);
    if (is_wr) check("req_data", uhost_req_data, {224'h0, exp_data});
    for (int i = 0; i < wait_n; i++) begin
      @(negedge clk);
      check("hold_valid", uhost_req_valid, 1);
      check("hold_cmd", uhost_req_cmd, exp_cmd);
      if (is_wr) check("hold_data", uhost_req_data, {224'h0, exp_data});
    end
    uhost_req_ready = 1'b1;
    @(negedge clk);
    uhost_req_ready = 1'b0;
    check("req_valid_after_hs", uhost_req_valid, 0);
    check("resp_ready", uhost_resp_ready, 1);
    uhost_resp_valid = 1'b1;
    uhost_resp_cmd   = rcmd;
    uhost_resp_data  = {32'hFFFF_FFFF, 192'h0, rdata};
    @(negedge clk);
    uhost_resp_valid = 1'b0;
    check("resp_ready_after", uhost_resp_ready, 0);
    check("busy_after", busy, 0);
  endtask

  typedef struct {
    logic        is_wr;
    logic [31:0] wdata;
    int          wait_n;
    logic [31:0] rcmd;
    logic [31:0] rdata;
    logic        exp_upd;
    logic [31:0] exp_gpio;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base;
    vecs[0] = '{1'b1, 32'hA5A5_0001, 0, RSP_WR, 32'h0,         1'b0, 32'hCAFE_0000, 1'b0};
    vecs[1] = '{1'b0, 32'h0,         0, RSP_RD, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b0};
    vecs[2] = '{1'b1, 32'hFFFF_FFFF, 5, RSP_WR, 32'h0,         1'b0, 32'h1234_5678, 1'b0};
    vecs[3] = '{1'b0, 32'h0,         2, RSP_RD, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1'b0};
    vecs[4] = '{1'b0, 32'h0,         0, RSP_WR, 32'h0000_0055, 1'b0, 32'hDEAD_BEEF, 1'b1};
    vecs[5] = '{1'b1, 32'h0000_0000, 0, RSP_WR, 32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1};

    nreset = 1'b0; set_valid = 1'b0; set_data = '0; sample_req = 1'b0;
    uhost_req_ready = 1'b0; uhost_resp_valid = 1'b0; uhost_resp_cmd = '0;
    uhost_resp_dstaddr = '0; uhost_resp_srcaddr = '0; uhost_resp_data = '0;
    repeat (3) @(negedge clk);
    check("rst_set_ready", set_ready, 0);
    check("rst_req_valid", uhost_req_valid, 0);
    check("rst_resp_ready", uhost_resp_ready, 0);
    check("rst_gpio_in_q", gpio_in_q, 0);
    check("rst_error", error, 0);
    check("rst_busy", busy, 0);
    nreset = 1'b1;

    // 100 idle cycles: polled DUT reads every 16 cycles, main DUT never reads
    repeat (100) @(negedge clk);
    check("poll_read_count", p_times.size(), 6);
    for (int i = 1; i < p_times.size(); i++)
      check("poll_spacing", p_times[i] - p_times[i-1], 16);
    check("nopoll_reads", hs_cnt, 0);
    check("idle_set_ready", set_ready, 1);

    // write and sample in the same cycle: write first, then exactly one read
    base = hs_cnt;
    start_set(32'h1111_2222, 1'b1);
    serve(1'b1, 32'h1111_2222, 0, RSP_WR, 32'h0);
    serve(1'b0, 32'h0, 0, RSP_RD, 32'hCAFE_0000);
    check("both_gpio", gpio_in_q, 32'hCAFE_0000);
    repeat (10) @(negedge clk);
    check("both_hs_count", hs_cnt - base, 2);
    check("both_error", error, 0);

    for (int v = 0; v < 6; v++) begin
      base = hs_cnt;
      if (vecs[v].is_wr) start_set(vecs[v].wdata, 1'b0);
      else pulse_sample();
      serve(vecs[v].is_wr, vecs[v].wdata, vecs[v].wait_n, vecs[v].rcmd, vecs[v].rdata);
      check("vec_upd", gpio_in_upd, vecs[v].exp_upd);
      check("vec_gpio", gpio_in_q, vecs[v].exp_gpio);
      check("vec_error", error, vecs[v].exp_err);
      @(negedge clk);
      check("vec_upd_end", gpio_in_upd, 0);
      check("vec_hs_count", hs_cnt - base, 1);
    end

    // reset while waiting for a read response
    pulse_sample();
    begin
      int n = 0;
      while (!uhost_req_valid && n < 20) begin @(negedge clk); n++; end
    end
    check("rr_req_valid", uhost_req_valid, 1);
    uhost_req_ready = 1'b1;
    @(negedge clk);
    uhost_req_ready = 1'b0;
    check("rr_in_resp", uhost_resp_ready, 1);
    nreset = 1'b0; sample_req = 1'b1; set_valid = 1'b1; set_data = 32'hFFFF_0000;
    @(negedge clk);
    check("rr_gpio_in_q", gpio_in_q, 0);
    check("rr_error", error, 0);
    check("rr_req_valid0", uhost_req_valid, 0);
    check("rr_resp_ready", uhost_resp_ready, 0);
    check("rr_set_ready", set_ready, 0);
    check("rr_busy", busy, 0);
    check("rr_upd", gpio_in_upd, 0);
    check("rr_req_cmd", uhost_req_cmd, 0);
    check("rr_req_dstaddr", uhost_req_dstaddr, 0);
    repeat (2) @(negedge clk);
    sample_req = 1'b0; set_valid = 1'b0;
    nreset = 1'b1;
    base = hs_cnt;
    repeat (10) @(negedge clk);
    check("rr_no_req_after", hs_cnt - base, 0);
    check("rr_idle_valid", uhost_req_valid, 0);
    check("rr_idle_busy", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
